// File: rtl/train_sensor_emulator.sv
// Emulated train crossing S1..S6: one PULSE_LEN-cycle pulse per sensor with seg_ticks idle cycles between pulses.
// First pulse is visible the cycle after start is accepted; pause stalls only travel, never a pulse, and every output is a flop.
module train_sensor_emulator #(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] seg_ticks,
    input  logic             pause,
    output logic             S1,
    output logic             S2,
    output logic             S3,
    output logic             S4,
    output logic             S5,
    output logic             S6,
    output logic             busy,
    output logic             done,
    output logic [2:0]       pos
);

    typedef enum logic [1:0] {IDLE, PULSE, TRAVEL, DONE} state_t;

    // One counter serves both pulse length and travel time, so it must hold either.
    localparam int             CW         = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [CW-1:0]  PULSE_LAST = CW'(PULSE_LEN - 1);

    state_t           state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] seg_q, seg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [5:0]       sens_q, sens_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       pos_q, pos_d;
    logic [2:0]       num_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        dir_d   = dir_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    seg_d   = (seg_ticks == '0) ? CNT_W'(1) : seg_ticks;
                    k_d     = 3'd0;
                    cnt_d   = PULSE_LAST;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    if (k_q == 3'd5) begin
                        state_d = DONE;
                    end else begin
                        state_d = TRAVEL;
                        cnt_d   = CW'(seg_q) - CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TRAVEL: begin
                if (!pause) begin
                    if (cnt_q == '0) begin
                        state_d = PULSE;
                        k_d     = k_q + 3'd1;
                        cnt_d   = PULSE_LAST;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it.
        num_d  = dir_d ? (3'd5 - k_d) : k_d;
        sens_d = (state_d == PULSE) ? (6'b000001 << num_d) : 6'b000000;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        pos_d  = (state_d == IDLE) ? 3'd7 : num_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            dir_q   <= 1'b0;
            seg_q   <= '0;
            cnt_q   <= '0;
            sens_q  <= 6'b000000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= 3'd7;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dir_q   <= dir_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            sens_q  <= sens_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
        end
    end

    assign S1   = sens_q[0];
    assign S2   = sens_q[1];
    assign S3   = sens_q[2];
    assign S4   = sens_q[3];
    assign S5   = sens_q[4];
    assign S6   = sens_q[5];
    assign busy = busy_q;
    assign done = done_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_train_sensor_emulator.sv
// Bench for train_sensor_emulator: directed table checkpoints plus randomized passes against an event-level timing model.
module tb_train_sensor_emulator;

    localparam int PL   = 2;
    localparam int CW   = 16;
    localparam int MAXN = 2000;

    logic          clk = 1'b0;
    logic          rst, start, dir, pause;
    logic [CW-1:0] seg_ticks;
    logic          S1, S2, S3, S4, S5, S6, busy, done;
    logic [2:0]    pos;

    always #5 clk = ~clk;

    train_sensor_emulator #(.PULSE_LEN(PL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .seg_ticks(seg_ticks), .pause(pause),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6),
        .busy(busy), .done(done), .pos(pos)
    );

    // Per-cycle stimulus, recorded DUT outputs and model expectations.
    bit            st_v [MAXN];
    bit            ps_v [MAXN];
    bit            rs_v [MAXN];
    bit            dr_v [MAXN];
    logic [CW-1:0] sg_v [MAXN];
    logic [5:0]    a_s  [MAXN];
    logic          a_b  [MAXN];
    logic          a_d  [MAXN];
    logic [2:0]    a_p  [MAXN];
    logic [5:0]    e_s  [MAXN];
    logic          e_b  [MAXN];
    logic          e_d  [MAXN];
    logic [2:0]    e_p  [MAXN];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         scen;
        int         cyc;
        logic [5:0] s;
        logic       b;
        logic       d;
        logic [2:0] p;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [10:0] pk(input logic [5:0] s, input logic b, input logic d, input logic [2:0] p);
        return {s, b, d, p};
    endfunction

    task automatic check(input string name, input int x, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got S6..S1/busy/done/pos=%b required %b", name, x, act, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            st_v[i] = 1'b0; ps_v[i] = 1'b0; rs_v[i] = 1'b0; dr_v[i] = 1'b0; sg_v[i] = '0;
        end
    endtask

    // Reference: accepted starts produce six pulses whose start cycles come from counting
    // un-paused travel cycles; reset truncates the pass; DUT is assumed idle in cycle 0.
    task automatic model(input int n);
        int c, t, sv, y, got, dn, end_c, last;
        int p[6];
        bit d;
        for (int x = 0; x < n; x++) begin
            e_s[x] = 6'b0; e_b[x] = 1'b0; e_d[x] = 1'b0; e_p[x] = 3'd7;
        end
        c = 0;
        while (c < n) begin
            if (rs_v[c] || !st_v[c]) begin
                c++;
            end else begin
                t  = c;
                d  = dr_v[t];
                sv = (sg_v[t] == 0) ? 1 : int'(sg_v[t]);
                p[0] = t + 1;
                for (int k = 1; k < 6; k++) begin
                    y = p[k-1] + PL;
                    got = 0;
                    while (got < sv) begin
                        if (!(y < n && ps_v[y])) got++;
                        y++;
                    end
                    p[k] = y;
                end
                dn = p[5] + PL;
                end_c = dn;
                for (int r = t + 1; r < dn; r++) begin
                    if (r < n && rs_v[r] && end_c == dn) end_c = r;
                end
                last = (end_c < n - 1) ? end_c : n - 1;
                for (int x = t + 1; x <= last; x++) begin
                    e_b[x] = 1'b1;
                    e_d[x] = (x == dn);
                    for (int k = 0; k < 6; k++) begin
                        if (x >= p[k]) begin
                            e_p[x] = d ? 3'(5 - k) : 3'(k);
                            if (x < p[k] + PL) e_s[x][d ? 5 - k : k] = 1'b1;
                        end
                    end
                end
                c = (end_c == dn) ? dn + 1 : end_c;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; pause = 1'b0; dir = 1'b0; seg_ticks = '0;
    endtask

    task automatic run_scen(input int n);
        for (int x = 0; x < n; x++) begin
            @(posedge clk); #1;
            rst = rs_v[x]; start = st_v[x]; pause = ps_v[x]; dir = dr_v[x]; seg_ticks = sg_v[x];
            @(negedge clk);
            a_s[x] = {S6, S5, S4, S3, S2, S1};
            a_b[x] = busy; a_d[x] = done; a_p[x] = pos;
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; pause = 1'b0; dir = 1'b0; seg_ticks = '0;
    endtask

    task automatic compare_all(input int n, input string tag);
        for (int x = 0; x < n; x++) begin
            check(tag, x, pk(a_s[x], a_b[x], a_d[x], a_p[x]), pk(e_s[x], e_b[x], e_d[x], e_p[x]));
            checks++;
            if ($countones(a_s[x]) > 1) begin
                errors++;
                $display("FAIL onehot %s cycle %0d: sensors=%b required at most one high", tag, x, a_s[x]);
            end
        end
    endtask

    initial begin
        int n, sg, dn, pulses, dones;
        rst = 1'b1; start = 1'b0; pause = 1'b0; dir = 1'b0; seg_ticks = '0;

        tbl.push_back('{0, 0, 6'b000000, 1'b0, 1'b0, 3'd7});
        tbl.push_back('{0, 1, 6'b000001, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{0, 2, 6'b000001, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{0, 3, 6'b000000, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{0, 6, 6'b000010, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{0, 11, 6'b000100, 1'b1, 1'b0, 3'd2});
        tbl.push_back('{0, 16, 6'b001000, 1'b1, 1'b0, 3'd3});
        tbl.push_back('{0, 22, 6'b010000, 1'b1, 1'b0, 3'd4});
        tbl.push_back('{0, 27, 6'b100000, 1'b1, 1'b0, 3'd5});
        tbl.push_back('{0, 28, 6'b000000, 1'b1, 1'b1, 3'd5});
        tbl.push_back('{0, 29, 6'b000000, 1'b0, 1'b0, 3'd7});
        tbl.push_back('{1, 1, 6'b100000, 1'b1, 1'b0, 3'd5});
        tbl.push_back('{1, 26, 6'b000001, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{1, 28, 6'b000000, 1'b1, 1'b1, 3'd0});
        tbl.push_back('{2, 6, 6'b000000, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{2, 16, 6'b000010, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{2, 17, 6'b000010, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{2, 28, 6'b000000, 1'b1, 1'b0, 3'd3});
        tbl.push_back('{2, 38, 6'b000000, 1'b1, 1'b1, 3'd5});
        tbl.push_back('{3, 6, 6'b000010, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{3, 28, 6'b000000, 1'b1, 1'b1, 3'd5});
        tbl.push_back('{4, 4, 6'b000010, 1'b1, 1'b0, 3'd1});
        tbl.push_back('{4, 17, 6'b100000, 1'b1, 1'b0, 3'd5});
        tbl.push_back('{4, 18, 6'b000000, 1'b1, 1'b1, 3'd5});
        tbl.push_back('{4, 19, 6'b000000, 1'b0, 1'b0, 3'd7});
        tbl.push_back('{5, 29, 6'b000000, 1'b0, 1'b0, 3'd7});
        tbl.push_back('{5, 30, 6'b000001, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{6, 11, 6'b000100, 1'b1, 1'b0, 3'd2});
        tbl.push_back('{6, 28, 6'b000000, 1'b1, 1'b1, 3'd5});
        tbl.push_back('{6, 30, 6'b000000, 1'b0, 1'b0, 3'd7});
        tbl.push_back('{7, 12, 6'b000100, 1'b1, 1'b0, 3'd2});
        tbl.push_back('{7, 13, 6'b000000, 1'b0, 1'b0, 3'd7});
        tbl.push_back('{7, 14, 6'b000000, 1'b0, 1'b0, 3'd7});
        tbl.push_back('{7, 16, 6'b000001, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{7, 17, 6'b000001, 1'b1, 1'b0, 3'd0});

        // Directed scenarios: all use PULSE_LEN=2, seg_ticks=3 unless noted.
        for (int sc = 0; sc < 8; sc++) begin
            clear_stim();
            n = 50;
            for (int i = 0; i < n; i++) begin
                sg_v[i] = (sc == 4) ? 16'd0 : 16'd3;
                dr_v[i] = (sc == 1);
            end
            st_v[0] = 1'b1;
            case (sc)
                2: for (int i = 4; i <= 13; i++) ps_v[i] = 1'b1;
                3: begin ps_v[1] = 1'b1; ps_v[2] = 1'b1; end
                5: for (int i = 0; i < n; i++) st_v[i] = 1'b1;
                6: st_v[10] = 1'b1;
                7: begin rs_v[12] = 1'b1; st_v[15] = 1'b1; end
                default: ;
            endcase
            do_reset();
            run_scen(n);
            model(n);
            compare_all(n, $sformatf("scen%0d_model", sc));
            foreach (tbl[j]) begin
                if (tbl[j].scen == sc)
                    check($sformatf("scen%0d_table", sc), tbl[j].cyc,
                          pk(a_s[tbl[j].cyc], a_b[tbl[j].cyc], a_d[tbl[j].cyc], a_p[tbl[j].cyc]),
                          pk(tbl[j].s, tbl[j].b, tbl[j].d, tbl[j].p));
            end
        end

        // Randomized passes with pause noise and ignored starts while busy.
        for (int pass = 0; pass < 200; pass++) begin
            clear_stim();
            sg = $urandom_range(1, 50);
            for (int i = 0; i < MAXN; i++) begin
                sg_v[i] = 16'(sg);
                dr_v[i] = (pass % 2 == 1);
                ps_v[i] = ($urandom_range(0, 3) == 0);
            end
            st_v[0] = 1'b1;
            model(MAXN);
            dn = MAXN - 3;
            for (int x = 0; x < MAXN; x++) if (e_d[x]) dn = x;
            st_v[$urandom_range(1, dn - 1)] = 1'b1;
            n = dn + 3;
            model(n);
            run_scen(n);
            compare_all(n, $sformatf("rand%0d", pass));
            pulses = 0;
            dones = 0;
            for (int x = 0; x < n; x++) begin
                if (a_d[x] === 1'b1) dones++;
                for (int b = 0; b < 6; b++)
                    if (a_s[x][b] === 1'b1 && (x == 0 || a_s[x-1][b] !== 1'b1)) pulses++;
            end
            check($sformatf("rand%0d_pulses", pass), pass, 11'(pulses), 11'd6);
            check($sformatf("rand%0d_dones", pass), pass, 11'(dones), 11'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
